// File: rtl/key_event_arbiter_if.sv
// Event port between the key front-end (master) and its consumer (slave):
// valid/ready handshake plus key index, direction and overflow pulse.
interface key_event_arbiter_if #(
  parameter int IDX_W = 2
);
  logic             event_valid;
  logic             event_ready;
  logic [IDX_W-1:0] event_idx;
  logic             event_press;
  logic             overflow;

  modport master (
    output event_valid,
    output event_idx,
    output event_press,
    output overflow,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_idx,
    input  event_press,
    input  overflow,
    output event_ready
  );
endinterface

// File: rtl/key_event_arbiter.sv
// Key front-end: 3-flop synchronizer, per-key debounce, pending events and a
// round-robin arbiter onto one registered event port. Define KEY_ARB_RELEASE_EN to also report releases.
module key_event_arbiter #(
  parameter int NUM_KEYS        = 4,
  parameter int IDX_W           = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_W            = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys_in,
  key_event_arbiter_if.master ev
);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_KEYS-1:0] stable_q, stable_d;
  logic [DB_W-1:0]     cnt_q [NUM_KEYS];
  logic [DB_W-1:0]     cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] chg_q, chg_d;
  logic [NUM_KEYS-1:0] pend_q, pend_d;
`ifdef KEY_ARB_RELEASE_EN
  logic [NUM_KEYS-1:0] pend_dir_q, pend_dir_d;
`endif

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic                valid_q, valid_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                press_q, press_d;
  logic                ovf_q, ovf_d;

  logic                gnt_found_s;
  logic [IDX_W-1:0]    gnt_idx_s;
  logic [IDX_W:0]      sum_s;
  logic [IDX_W:0]      scan_s;
  logic [NUM_KEYS-1:0] grant_oh_s;

  // Synchronizer chain; sync3_q is the synchronized key level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= keys_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    chg_d    = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (sync3_q[k] == stable_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt_d[k]    = '0;
        stable_d[k] = sync3_q[k];
`ifdef KEY_ARB_RELEASE_EN
        chg_d[k]    = 1'b1;
`else
        chg_d[k]    = sync3_q[k];
`endif
      end else begin
        cnt_d[k] = cnt_q[k] + DB_W'(1);
      end
    end
  end

  // Debounce state; the change event is registered so pending logic sees the new stable level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
      chg_q    <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      chg_q    <= chg_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Round-robin search: first pending key at or above rr_q, wrapping mod NUM_KEYS.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    sum_s       = '0;
    scan_s      = '0;
    for (int off = 0; off < NUM_KEYS; off++) begin
      sum_s  = {1'b0, rr_q} + (IDX_W+1)'(off);
      scan_s = (sum_s >= (IDX_W+1)'(NUM_KEYS)) ? (sum_s - (IDX_W+1)'(NUM_KEYS)) : sum_s;
      if (!gnt_found_s && pend_q[scan_s[IDX_W-1:0]]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = scan_s[IDX_W-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Presentation FSM, pending bookkeeping and overflow detection.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    idx_d      = idx_q;
    press_d    = press_q;
    rr_d       = rr_q;
    grant_oh_s = '0;
    case (state_q)
      IDLE: begin
        if (gnt_found_s) begin
          grant_oh_s[gnt_idx_s] = 1'b1;
          valid_d = 1'b1;
          idx_d   = gnt_idx_s;
`ifdef KEY_ARB_RELEASE_EN
          press_d = pend_dir_q[gnt_idx_s];
`else
          press_d = 1'b1;
`endif
          rr_d    = (gnt_idx_s == IDX_W'(NUM_KEYS - 1)) ? '0 : (gnt_idx_s + IDX_W'(1));
          state_d = PRESENT;
        end else begin
          state_d = IDLE;
        end
      end
      PRESENT: begin
        if (valid_q && ev.event_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = PRESENT;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    // A change landing on a key being granted this cycle re-arms it without overflow.
    pend_d = (pend_q & ~grant_oh_s) | chg_q;
    ovf_d  = |(chg_q & pend_q & ~grant_oh_s);
`ifdef KEY_ARB_RELEASE_EN
    pend_dir_d = (pend_dir_q & ~chg_q) | (stable_q & chg_q);
`endif
  end

  // Arbiter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      pend_q     <= '0;
`ifdef KEY_ARB_RELEASE_EN
      pend_dir_q <= '0;
`endif
      valid_q    <= 1'b0;
      idx_q      <= '0;
      press_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      pend_q     <= pend_d;
`ifdef KEY_ARB_RELEASE_EN
      pend_dir_q <= pend_dir_d;
`endif
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      press_q    <= press_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ev.event_valid = valid_q;
  assign ev.event_idx   = idx_q;
  assign ev.event_press = press_q;
  assign ev.overflow    = ovf_q;

endmodule
